// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch
// Pixel-supply stage in front of the VGA timing/output block. Source pixels are
// buffered in a small synchronous FIFO. The stream is locked to the raster using
// start-of-frame markers plus a vsync pulse. One pixel is then delivered per
// active-display cycle as registered 10-bit R/G/B.
// On misalignment or starvation the block drives black and re-locks on the next
// frame start.
//
// Optional feature macro: VGA_PIXFETCH_STATS_EN
//   Defined   -> underflow_cnt counts starved active cycles (saturating).
//   Undefined -> underflow_cnt is tied to zero.
//
// Ports
//   CLK            pixel clock, all logic on its rising edge
//   RST            asynchronous active-high reset
//   s_valid        source pixel valid
//   s_sof          source pixel is the first pixel of a frame
//   s_data[29:0]   source pixel {R,G,B}, 10 bits each
//   s_ready        FIFO not full (combinational)
//   disp_en        current cycle is an active display pixel
//   vsync_n        active-low vertical sync from the timing block
//   pix_r/g/b      registered output pixel, one cycle behind disp_en
//   locked         high while the fetch FSM is in RUN
//   underflow_cnt  starvation counter (see macro above)

module vga_pixel_fetch #(
    parameter int HDISP = 640,
    parameter int VDISP = 480,
    parameter int DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        s_valid,
    input  logic        s_sof,
    input  logic [29:0] s_data,
    output logic        s_ready,
    input  logic        disp_en,
    input  logic        vsync_n,
    output logic [9:0]  pix_r,
    output logic [9:0]  pix_g,
    output logic [9:0]  pix_b,
    output logic        locked,
    output logic [15:0] underflow_cnt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int PIXN = HDISP * VDISP;
    localparam int CW   = $clog2(PIXN);
    localparam logic [CW-1:0] LAST = CW'(PIXN - 1);

    typedef enum logic [1:0] {SEEK, ARMED, RUN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [30:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_vs;
    logic [29:0]   r_pix;
    logic          r_locked;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_consume;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_head_sof;
    logic [29:0]   w_head_data;
    logic [CW-1:0] w_idx;
    logic [29:0]   w_pix_d;

    // FIFO status: the extra pointer MSB distinguishes full from empty.
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) &&
                         (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign s_ready     = !w_full;
    assign w_push      = s_valid && !w_full;
    assign w_head_sof  = r_mem[r_rptr[AW-1:0]][30];
    assign w_head_data = r_mem[r_rptr[AW-1:0]][29:0];

    // Index of the pixel a RUN cycle would deliver; r_cnt holds the last one.
    assign w_idx = r_cnt + CW'(1);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {s_sof, s_data};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= SEEK;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. ARMED drops back to SEEK when the head is not a frame
    // start, which happens after a frame that was shifted by starvation.
    always_comb begin
        w_next = r_state;
        case (r_state)
            SEEK: begin
                if (!w_empty && w_head_sof) w_next = ARMED;
            end
            ARMED: begin
                if (!w_empty) begin
                    if (!w_head_sof)           w_next = SEEK;
                    else if (r_vs && disp_en)  w_next = RUN;
                end
            end
            RUN: begin
                if (disp_en) begin
                    if (!w_empty && w_head_sof) w_next = ARMED;
                    else if (w_idx == LAST)     w_next = ARMED;
                end
            end
            default: w_next = SEEK;
        endcase
    end

    // Output/datapath control. A misaligned sof in RUN is left at the head so
    // that ARMED can relock on it directly.
    always_comb begin
        w_pop     = 1'b0;
        w_consume = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            SEEK: begin
                w_pop = !w_empty && !w_head_sof;
            end
            ARMED: begin
                if (!w_empty && w_head_sof && r_vs && disp_en) begin
                    w_pop     = 1'b1;
                    w_consume = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            RUN: begin
                if (disp_en) begin
                    if (w_empty) begin
                        w_cnt_inc = 1'b1;
                    end else if (!w_head_sof) begin
                        w_pop     = 1'b1;
                        w_consume = 1'b1;
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign w_pix_d = w_consume ? w_head_data : 30'd0;

    // Pixel counter, vsync sticky flag, output pixel and lock indication.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            r_vs     <= 1'b0;
            r_pix    <= '0;
            r_locked <= 1'b0;
        end else begin
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= w_idx;
            if (r_state == ARMED && w_next == RUN) r_vs <= 1'b0;
            else if (!vsync_n)                     r_vs <= 1'b1;
            r_pix    <= w_pix_d;
            r_locked <= (w_next == RUN);
        end
    end

    assign pix_r  = r_pix[29:20];
    assign pix_g  = r_pix[19:10];
    assign pix_b  = r_pix[9:0];
    assign locked = r_locked;

`ifdef VGA_PIXFETCH_STATS_EN
    logic        w_starve;
    logic [15:0] r_uf;

    assign w_starve = (r_state == RUN) && disp_en && w_empty;

    // Starvation counter, saturating so it never wraps back to a clean value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_uf <= 16'h0000;
        end else if (w_starve && r_uf != 16'hFFFF) begin
            r_uf <= r_uf + 16'd1;
        end
    end

    assign underflow_cnt = r_uf;
`else
    assign underflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch
// Directed bench for vga_pixel_fetch using a tiny raster (4x2 pixels, 4-entry FIFO)
// so that every cycle can be written out by hand. Each table row gives the
// inputs for one clock cycle and the outputs expected just after that edge.
// Covered cases:
//   - stray pixels discarded
//   - FIFO full and refill
//   - lock on sof plus vsync
//   - a full frame
//   - starvation gaps and the realignment that follows
//   - an injected sof mid-frame
//   - asynchronous reset and relock

module tb_vga_pixel_fetch;

    logic        CLK = 1'b0;
    logic        RST;
    logic        s_valid;
    logic        s_sof;
    logic [29:0] s_data;
    logic        s_ready;
    logic        disp_en;
    logic        vsync_n;
    logic [9:0]  pix_r;
    logic [9:0]  pix_g;
    logic [9:0]  pix_b;
    logic        locked;
    logic [15:0] underflow_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic v;
        logic sof;
        int   d;
        logic de;
        logic vsn;
        logic rdy;
        int   px;
        logic lk;
        int   uf;
    } vec_t;

    vec_t tA[35];
    vec_t tB[5];

    vga_pixel_fetch #(.HDISP(4), .VDISP(2), .DEPTH(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .s_valid(s_valid),
        .s_sof(s_sof),
        .s_data(s_data),
        .s_ready(s_ready),
        .disp_en(disp_en),
        .vsync_n(vsync_n),
        .pix_r(pix_r),
        .pix_g(pix_g),
        .pix_b(pix_b),
        .locked(locked),
        .underflow_cnt(underflow_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [29:0] mkPix(input int k);
        mkPix = {10'(k), 10'(k + 7), 10'(k * 3 + 1)};
    endfunction

    function automatic vec_t mk(input logic v, input logic sof, input int d,
                                input logic de, input logic vsn, input logic rdy,
                                input int px, input logic lk, input int uf);
        vec_t t;
        t.v = v; t.sof = sof; t.d = d; t.de = de; t.vsn = vsn;
        t.rdy = rdy; t.px = px; t.lk = lk; t.uf = uf;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        s_valid = t.v;
        s_sof   = t.sof;
        s_data  = t.v ? mkPix(t.d) : 30'd0;
        disp_en = t.de;
        vsync_n = t.vsn;
    endtask

    task automatic checkOutput(input string name, input vec_t t);
        logic [29:0] expPix;
        logic [15:0] expUf;
        logic [29:0] gotPix;
        expPix = (t.px < 0) ? 30'd0 : mkPix(t.px);
`ifdef VGA_PIXFETCH_STATS_EN
        expUf = 16'(t.uf);
`else
        expUf = 16'h0000;
`endif
        gotPix = {pix_r, pix_g, pix_b};
        vectors++;
        if (s_ready !== t.rdy || gotPix !== expPix || locked !== t.lk ||
            underflow_cnt !== expUf) begin
            miscompares++;
            $display("[TB] FAIL %s: got rdy=%0b pix=%h lk=%0b uf=%0d, want rdy=%0b pix=%h lk=%0b uf=%0d",
                     name, s_ready, gotPix, locked, underflow_cnt,
                     t.rdy, expPix, t.lk, expUf);
        end
    endtask

    initial begin
        // Frame 1 (data 0..7) preceded by two strays, with a full FIFO before lock.
        tA[0]  = mk(1, 0, 100, 0, 1,  1, -1, 0, 0);
        tA[1]  = mk(1, 0, 101, 0, 1,  1, -1, 0, 0);
        tA[2]  = mk(1, 1,   0, 0, 1,  1, -1, 0, 0);
        tA[3]  = mk(1, 0,   1, 0, 1,  1, -1, 0, 0);
        tA[4]  = mk(1, 0,   2, 0, 0,  1, -1, 0, 0);
        tA[5]  = mk(1, 0,   3, 0, 1,  0, -1, 0, 0);
        tA[6]  = mk(1, 0,   4, 1, 1,  1,  0, 1, 0);
        tA[7]  = mk(1, 0,   4, 1, 1,  1,  1, 1, 0);
        tA[8]  = mk(1, 0,   5, 1, 1,  1,  2, 1, 0);
        tA[9]  = mk(1, 0,   6, 1, 1,  1,  3, 1, 0);
        tA[10] = mk(1, 0,   7, 0, 1,  0, -1, 1, 0);
        tA[11] = mk(0, 0,   0, 1, 1,  1,  4, 1, 0);
        tA[12] = mk(0, 0,   0, 1, 1,  1,  5, 1, 0);
        tA[13] = mk(0, 0,   0, 1, 1,  1,  6, 1, 0);
        tA[14] = mk(0, 0,   0, 1, 1,  1,  7, 0, 0);
        // Frame 2 (data 10..) with source gaps: four starved active cycles.
        tA[15] = mk(1, 1,  10, 0, 0,  1, -1, 0, 0);
        tA[16] = mk(1, 0,  11, 1, 1,  1, 10, 1, 0);
        tA[17] = mk(0, 0,   0, 1, 1,  1, 11, 1, 0);
        tA[18] = mk(0, 0,   0, 1, 1,  1, -1, 1, 1);
        tA[19] = mk(0, 0,   0, 1, 1,  1, -1, 1, 2);
        tA[20] = mk(1, 0,  12, 1, 1,  1, -1, 1, 3);
        tA[21] = mk(1, 0,  13, 1, 1,  1, 12, 1, 3);
        tA[22] = mk(0, 0,   0, 1, 1,  1, 13, 1, 3);
        tA[23] = mk(1, 0,  14, 1, 1,  1, -1, 0, 4);
        // Leftover pixel 14 is discarded, frame 3 (data 20..) realigns.
        tA[24] = mk(1, 1,  20, 0, 0,  1, -1, 0, 4);
        tA[25] = mk(0, 0,   0, 0, 1,  1, -1, 0, 4);
        tA[26] = mk(0, 0,   0, 0, 1,  1, -1, 0, 4);
        tA[27] = mk(0, 0,   0, 1, 1,  1, 20, 1, 4);
        // Injected sof (data 22) at pixel index 2: black, unlock, relock on it.
        tA[28] = mk(1, 0,  21, 0, 1,  1, -1, 1, 4);
        tA[29] = mk(1, 1,  22, 1, 1,  1, 21, 1, 4);
        tA[30] = mk(1, 0,  23, 1, 1,  1, -1, 0, 4);
        tA[31] = mk(0, 0,   0, 1, 1,  1, -1, 0, 4);
        tA[32] = mk(0, 0,   0, 0, 0,  1, -1, 0, 4);
        tA[33] = mk(0, 0,   0, 1, 1,  1, 22, 1, 4);
        tA[34] = mk(0, 0,   0, 1, 1,  1, 23, 1, 4);
        // After reset: sof alone is not enough, a fresh vsync pulse is required.
        tB[0]  = mk(1, 1,  40, 0, 1,  1, -1, 0, 0);
        tB[1]  = mk(0, 0,   0, 1, 1,  1, -1, 0, 0);
        tB[2]  = mk(0, 0,   0, 1, 1,  1, -1, 0, 0);
        tB[3]  = mk(0, 0,   0, 0, 0,  1, -1, 0, 0);
        tB[4]  = mk(0, 0,   0, 1, 1,  1, 40, 1, 0);

        RST = 1'b1;
        applyStimulus(mk(0, 0, 0, 0, 1, 1, -1, 0, 0));
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset", mk(0, 0, 0, 0, 1, 1, -1, 0, 0));
        RST = 1'b0;

        for (int i = 0; i < 35; i++) begin
            applyStimulus(tA[i]);
            @(posedge CLK);
            #1;
            checkOutput($sformatf("A%0d", i + 1), tA[i]);
        end

        // Mid-frame reset must clear outputs without waiting for a clock edge.
        applyStimulus(mk(0, 0, 0, 0, 1, 1, -1, 0, 0));
        #2;
        RST = 1'b1;
        #1;
        checkOutput("rst_async", mk(0, 0, 0, 0, 1, 1, -1, 0, 0));
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(tB[i]);
            @(posedge CLK);
            #1;
            checkOutput($sformatf("B%0d", i + 1), tB[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
